// File: rtl/rga_countdown_timer.sv
// rtl/rga_countdown_timer.sv - BCD mm:ss countdown timer with run/pause FSM and 4-digit 7-segment scan
// Preset is range-checked on load; expiry can optionally reload the latched preset and keep running.
module rga_countdown_timer #(
  parameter int TICK_DIV    = 4,
  parameter int SCAN_DIV    = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        i_new_clock,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [15:0] i_preset,
  input  logic        i_start,
  input  logic        i_pause,
  output logic [15:0] o_time_bcd,
  output logic [6:0]  o_segments,
  output logic [3:0]  o_digit_en,
  output logic        o_running,
  output logic        o_stop,
  output logic        o_done,
  output logic        o_load_err
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [15:0]   r_time, w_time_next;
  logic [15:0]   r_latch, w_latch_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic          r_running, r_done, r_load_err;
  logic          w_done, w_load_err, w_tick, w_load_ok, w_presc_wrap;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_scan_idx;
  logic [3:0]    r_digit_en;
  logic [3:0]    w_nibble;

  function automatic logic bcd_valid(input logic [15:0] t);
    return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (t[11:8] <= 4'd9) && (t[15:12] <= 4'd5);
  endfunction

  // Callers guarantee t != 0, so the tens-of-minutes digit never underflows.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign w_load_ok    = bcd_valid(i_preset);
  assign w_presc_wrap = (r_presc == PW'(TICK_DIV - 1));
  assign w_tick       = (r_state == ST_RUN) && w_presc_wrap && (r_time != 16'h0000);

  always_comb begin
    w_state_next = r_state;
    w_time_next  = r_time;
    w_latch_next = r_latch;
    w_presc_next = r_presc;
    w_done       = 1'b0;
    w_load_err   = 1'b0;
    // Any load request outranks pause/start and the tick for that cycle.
    if (i_load) begin
      if (w_load_ok) begin
        w_time_next  = i_preset;
        w_latch_next = i_preset;
        w_presc_next = '0;
        w_state_next = ST_IDLE;
      end else begin
        w_load_err = 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && (r_time != 16'h0000)) begin
            w_state_next = ST_RUN;
            w_presc_next = '0;
          end
        end
        ST_RUN: begin
          if (i_pause) begin
            w_state_next = ST_PAUSED;
          end else begin
            w_presc_next = w_presc_wrap ? '0 : r_presc + PW'(1);
            if (w_tick) begin
              w_time_next = bcd_dec(r_time);
              if (r_time == 16'h0001) begin
                w_done = 1'b1;
                if (!(AUTO_RELOAD && (r_latch != 16'h0000))) w_state_next = ST_DONE;
              end
            end else if (AUTO_RELOAD && (r_time == 16'h0000) && (r_latch != 16'h0000)) begin
              w_time_next = r_latch;
            end
          end
        end
        ST_PAUSED: begin
          if (i_start) w_state_next = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_new_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_time     <= '0;
      r_latch    <= '0;
      r_presc    <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_time     <= w_time_next;
      r_latch    <= w_latch_next;
      r_presc    <= w_presc_next;
      r_running  <= (w_state_next == ST_RUN);
      r_done     <= w_done;
      r_load_err <= w_load_err;
    end
  end

  always_ff @(posedge i_new_clock) begin
    if (i_reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 2'd0;
      r_digit_en <= 4'b0001;
    end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
      r_digit_en <= 4'b0001 << (r_scan_idx + 2'd1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  always_comb begin
    w_nibble = r_time[3:0];
    case (r_scan_idx)
      2'd1:    w_nibble = r_time[7:4];
      2'd2:    w_nibble = r_time[11:8];
      2'd3:    w_nibble = r_time[15:12];
      default: w_nibble = r_time[3:0];
    endcase
  end

  always_comb begin
    o_segments = 7'h00;
    case (w_nibble)
      4'd0:    o_segments = 7'h3F;
      4'd1:    o_segments = 7'h06;
      4'd2:    o_segments = 7'h5B;
      4'd3:    o_segments = 7'h4F;
      4'd4:    o_segments = 7'h66;
      4'd5:    o_segments = 7'h6D;
      4'd6:    o_segments = 7'h7D;
      4'd7:    o_segments = 7'h07;
      4'd8:    o_segments = 7'h7F;
      4'd9:    o_segments = 7'h6F;
      default: o_segments = 7'h00;
    endcase
  end

  assign o_time_bcd = r_time;
  assign o_digit_en = r_digit_en;
  assign o_running  = r_running;
  assign o_stop     = (r_time == 16'h0000);
  assign o_done     = r_done;
  assign o_load_err = r_load_err;

endmodule
